// File: rtl/lfsr_prng.sv
// Maximal-length XNOR-feedback LFSR with synchronous reseed and a seed-match flag.
// Optional define LFSR_LOCKUP_RECOVER_EN steps the all-ones lock-up state to zero.
module lfsr_prng #(
  parameter int NUM_BITS = 128
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);

  // No handshake: i_Enable qualifies every edge, i_Seed_DV only matters while
  // i_Enable is high, and consumers sample o_LFSR_Data on their own clock.

  // Tap bit numbers are 1-based; the MSB (bit NUM_BITS) is always a tap.
  localparam int TAP_B = (NUM_BITS == 8)  ? 6   :
                         (NUM_BITS == 16) ? 15  :
                         (NUM_BITS == 32) ? 22  :
                         (NUM_BITS == 64) ? 63  :
                         (NUM_BITS == 128) ? 126 : 1;
  localparam int TAP_C = (NUM_BITS == 8)  ? 5   :
                         (NUM_BITS == 16) ? 13  :
                         (NUM_BITS == 32) ? 2   :
                         (NUM_BITS == 64) ? 61  :
                         (NUM_BITS == 128) ? 101 : 1;
  localparam int TAP_D = (NUM_BITS == 8)  ? 4   :
                         (NUM_BITS == 16) ? 4   :
                         (NUM_BITS == 32) ? 1   :
                         (NUM_BITS == 64) ? 60  :
                         (NUM_BITS == 128) ? 99  : 1;

  localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_BITS-1:0] TAP_MASK = (ONE << (NUM_BITS - 1)) |
                                             (ONE << (TAP_B - 1)) |
                                             (ONE << (TAP_C - 1)) |
                                             (ONE << (TAP_D - 1));

  generate
    if (NUM_BITS != 8 && NUM_BITS != 16 && NUM_BITS != 32 &&
        NUM_BITS != 64 && NUM_BITS != 128) begin : g_bad_width
      $error("lfsr_prng: unsupported NUM_BITS %0d", NUM_BITS);
    end
  endgenerate

  logic [NUM_BITS-1:0] r;
  logic [NUM_BITS-1:0] r_next;
  logic                fb;

  always_comb begin
    fb     = ~(^(r & TAP_MASK));
    r_next = {r[NUM_BITS-2:0], fb};
`ifdef LFSR_LOCKUP_RECOVER_EN
    // All-ones is only reachable by seeding it; break out to zero.
    if (&r) begin
      r_next = '0;
    end
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r <= '0;
    end else if (i_Enable) begin
      if (i_Seed_DV) begin
        r <= i_Seed_Data;
      end else begin
        r <= r_next;
      end
    end
  end

  assign o_LFSR_Data = r;
  assign o_LFSR_Done = (r == i_Seed_Data);

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: 8-bit and 128-bit instances on one clock,
// hand-computed sequences, period/distinctness sweep, hold, reset and lock-up.
module tb_lfsr_prng;

  logic         clk;
  logic         rst_n;

  logic         en8;
  logic         dv8;
  logic [7:0]   seed8;
  logic [7:0]   data8;
  logic         done8;

  logic         en128;
  logic         dv128;
  logic [127:0] seed128;
  logic [127:0] data128;
  logic         done128;

  int checks;
  int errors;

  lfsr_prng #(.NUM_BITS(8)) dut8 (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Enable    (en8),
    .i_Seed_DV   (dv8),
    .i_Seed_Data (seed8),
    .o_LFSR_Data (data8),
    .o_LFSR_Done (done8)
  );

  lfsr_prng #(.NUM_BITS(128)) dut128 (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Enable    (en128),
    .i_Seed_DV   (dv128),
    .i_Seed_Data (seed128),
    .o_LFSR_Data (data128),
    .o_LFSR_Done (done128)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] lock_next;
  logic [7:0] held;
  bit         seen[256];
  int         dup_cnt;
  int         ff_cnt;
  int         early_done;

  initial begin
    checks     = 0;
    errors     = 0;
    dup_cnt    = 0;
    ff_cnt     = 0;
    early_done = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    lock_next = 8'h00;
`else
    lock_next = 8'hFF;
`endif

    rst_n   = 1'b0;
    en8     = 1'b1;
    dv8     = 1'b0;
    seed8   = 8'h33;
    en128   = 1'b0;
    dv128   = 1'b0;
    seed128 = '0;
    tick();
    tick();

    // Reset state
    check("rst_data8", {120'd0, data8}, 128'd0);
    check("rst_done8", {127'd0, done8}, 128'd0);
    check("rst_data128", data128, 128'd0);
    check("rst_done128_seed0", {127'd0, done128}, 128'd1);

    // Release between edges; first edge with rst_n high steps normally.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tick();
      check("seq8_from_zero", {120'd0, data8}, {120'd0, exp_v});
    end

    // 128-bit seed load and one step
    seed128 = {4{32'hDEADBEEF}};
    en128   = 1'b1;
    dv128   = 1'b1;
    tick();
    check("load128_data", data128, {4{32'hDEADBEEF}});
    check("load128_done", {127'd0, done128}, 128'd1);
    dv128 = 1'b0;
    tick();
    check("step128_data", data128, {4{32'hBD5B7DDF}});
    check("step128_done", {127'd0, done128}, 128'd0);
    en128 = 1'b0;

    // Full-period sweep from seed 0x5A
    seed8 = 8'h5A;
    dv8   = 1'b1;
    tick();
    check("load8_done", {127'd0, done8}, 128'd1);
    dv8 = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (seen[data8]) dup_cnt++;
      seen[data8] = 1'b1;
      if (data8 == 8'hFF) ff_cnt++;
      if (k < 255 && done8) early_done++;
    end
    check("period8_done_at_255", {127'd0, done8}, 128'd1);
    check("period8_data_back_to_seed", {120'd0, data8}, 128'h5A);
    check("period8_no_early_done", 128'(early_done), 128'd0);
    check("period8_distinct", 128'(dup_cnt), 128'd0);
    check("period8_no_ff", 128'(ff_cnt), 128'd0);

    // Hold: enable low ignores seed valid
    en8   = 1'b0;
    dv8   = 1'b1;
    seed8 = 8'h11;
    held  = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold8_data", {120'd0, data8}, {120'd0, held});
    end
    check("hold8_done_seed_differs", {127'd0, done8}, 128'd0);
    seed8 = 8'h5A;
    #1;
    check("hold8_done_seed_matches", {127'd0, done8}, 128'd1);

    // Asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    check("async_rst_data8", {120'd0, data8}, 128'd0);
    check("async_rst_data128", data128, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en8   = 1'b1;
    dv8   = 1'b0;
    tick();
    check("restart8_after_rst", {120'd0, data8}, 128'h01);

    // Seed valid held high reloads every cycle
    seed8 = 8'h77;
    dv8   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reload8_data", {120'd0, data8}, 128'h77);
      check("reload8_done", {127'd0, done8}, 128'd1);
    end

    // All-ones lock-up
    seed8 = 8'hFF;
    tick();
    check("lock8_loaded", {120'd0, data8}, 128'hFF);
    dv8 = 1'b0;
    tick();
    check("lock8_step1", {120'd0, data8}, {120'd0, lock_next});
    tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("lock8_step2", {120'd0, data8}, 128'h01);
`else
    check("lock8_step2", {120'd0, data8}, 128'hFF);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
